// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory read port: single-outstanding req/rvalid handshake
// between the fetch stage (master) and instruction memory (slave).
interface inst_fetch_stage_if #(
  parameter int ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: holds the PC, issues one word read at a time,
// registers returned words into the IF/ID register, absorbs a stall with a
// one-entry skid buffer and redirects on a taken branch, discarding any
// response that belongs to a fetch made stale by the redirect.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  inst_fetch_stage_if.master  imem,
  output logic [31:0]         INST,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                inst_valid
);

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic [31:0]       ifid_inst_q, ifid_inst_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;

  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] target_s;
  logic              accept_s;
  logic              load_mem_s;
  logic              load_skid_s;

  // Wrapping PC increment, aligned redirect target, IF/ID accept condition.
  assign pc_inc_s = pc_q + ADDR_W'(3'd4);
  assign target_s = branch_target & ~(ADDR_W'(2'b11));
  assign accept_s = !ifid_valid_q || !stall;

  // A request is issued only from S_ISSUE and never while reset is held.
  assign imem.imem_req  = (state_q == S_ISSUE) && !rst;
  assign imem.imem_addr = pc_q;

  // Fetch sequencing: next state, next PC and skid capture.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_pc4_d  = skid_pc4_q;
    load_mem_s  = 1'b0;
    load_skid_s = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (branch_taken) begin
          // The request just issued targets the old path.
          pc_d    = target_s;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          pc_d    = target_s;
          state_d = imem.imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem.imem_rvalid) begin
          pc_d = pc_inc_s;
          if (accept_s) begin
            load_mem_s = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            skid_inst_d = imem.imem_rdata;
            skid_pc_d   = pc_q;
            skid_pc4_d  = pc_inc_s;
            state_d     = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        state_d = imem.imem_rvalid ? S_ISSUE : S_DROP;
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = target_s;
          state_d = S_ISSUE;
        end else if (!stall) begin
          load_skid_s = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // IF/ID update: flush beats hold, hold beats a new word, else bubble.
  always_comb begin
    ifid_inst_d  = 32'd0;
    ifid_pc_d    = '0;
    ifid_pc4_d   = '0;
    ifid_valid_d = 1'b0;
    if (branch_taken) begin
      ifid_valid_d = 1'b0;
    end else if (stall && ifid_valid_q) begin
      ifid_inst_d  = ifid_inst_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = 1'b1;
    end else if (load_mem_s) begin
      ifid_inst_d  = imem.imem_rdata;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_inc_s;
      ifid_valid_d = 1'b1;
    end else if (load_skid_s) begin
      ifid_inst_d  = skid_inst_q;
      ifid_pc_d    = skid_pc_q;
      ifid_pc4_d   = skid_pc4_q;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_valid_d = 1'b0;
    end
  end

  // State, PC, skid and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= ADDR_W'(RESET_PC);
      skid_inst_q  <= 32'd0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      ifid_inst_q  <= 32'd0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign INST       = ifid_inst_q;
  assign pc_out     = ifid_pc_q;
  assign pc_plus4   = ifid_pc4_q;
  assign inst_valid = ifid_valid_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: directed scenarios push expected
// request addresses and IF/ID loads; a monitor pops and compares them as the
// DUT presents requests and newly loaded instructions.
module tb_inst_fetch_stage;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } load_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] INST;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        inst_valid;

  inst_fetch_stage_if #(.ADDR_W(32)) imem ();

  inst_fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .INST          (INST),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .inst_valid    (inst_valid)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] req_q[$];
  load_t       load_q[$];
  logic        mon_en = 1'b0;

  // memory model state
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] dxor = 32'd0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] addr_seen = 32'd0;
  logic        req_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory: responds lat cycles after a request with data = addr ^ dxor.
  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      req_seen  = imem.imem_req;
      addr_seen = imem.imem_addr;
      if (rst) cnt = 0;
      @(posedge clk);
      #1;
      imem.imem_rvalid = 1'b0;
      if (req_seen) begin
        cnt   = lat;
        paddr = addr_seen;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = paddr ^ dxor;
        end
      end
    end
  end

  // Monitor: compare each request and each newly loaded IF/ID word.
  initial begin
    logic        prev_valid;
    logic [31:0] prev_pc;
    logic [31:0] ea;
    load_t       el;
    prev_valid = 1'b0;
    prev_pc    = 32'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (imem.imem_req === 1'b1) begin
          if (req_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_addr: got unexpected request at %h", imem.imem_addr);
          end else begin
            ea = req_q.pop_front();
            chk("req_addr", imem.imem_addr, ea);
          end
        end
        if (inst_valid === 1'b1 && (!prev_valid || pc_out != prev_pc)) begin
          if (load_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ifid_load: got unexpected load INST=%h pc=%h", INST, pc_out);
          end else begin
            el = load_q.pop_front();
            chk("ifid_inst", INST, el.inst);
            chk("ifid_pc", pc_out, el.pc);
            chk("ifid_pc4", pc_plus4, el.pc4);
          end
        end
      end
      prev_valid = inst_valid;
      prev_pc    = pc_out;
    end
  end

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_load(input logic [31:0] pc);
    load_t l;
    l.inst = pc ^ dxor;
    l.pc   = pc;
    l.pc4  = pc + 32'd4;
    load_q.push_back(l);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset (checking the asynchronous clear), then release at cycle 0.
  task automatic start_test(input int l, input logic [31:0] x);
    mon_en        = 1'b0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    #1;
    chk("rst_inst", INST, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    req_q.delete();
    load_q.delete();
    cyc(1);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    lat  = l;
    dxor = x;
    cyc(1);
    mon_en = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic end_test(input string name);
    int n = 0;
    while ((req_q.size() != 0 || load_q.size() != 0) && n < 200) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (req_q.size() != 0 || load_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d reqs %0d loads outstanding, expected 0", name,
               req_q.size(), load_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    while (!(imem.imem_req === 1'b1 && imem.imem_addr === a) && n < 100) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (!(imem.imem_req === 1'b1 && imem.imem_addr === a)) begin
      miscompares++;
      $display("FAIL %s: got no request at %h, expected one", name, a);
    end
  endtask

  task automatic wait_inst(input logic [31:0] v, input string name);
    int n = 0;
    while (!(inst_valid === 1'b1 && INST === v) && n < 100) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (!(inst_valid === 1'b1 && INST === v)) begin
      miscompares++;
      $display("FAIL %s: got INST %h, expected %h valid", name, INST, v);
    end
  endtask

  initial begin
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    cyc(2);

    // 1: sequential fetch, 1-cycle memory, addr-as-data
    start_test(1, 32'd0);
    for (int i = 0; i < 4; i++) push_req(32'(i * 4));
    for (int i = 0; i < 3; i++) push_load(32'(i * 4));
    end_test("seq");

    // 2: reset asserted while waiting on memory
    start_test(3, 32'd0);
    push_req(32'h0); push_req(32'h4); push_req(32'h8);
    push_load(32'h0); push_load(32'h4);
    wait_inst(32'h4, "rst_mid_load4");
    stall = 1'b1;
    cyc(1);
    chk("pre_rst_inst", INST, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_inst", INST, 32'd0);
    chk("async_pc_out", pc_out, 32'd0);
    chk("async_pc_plus4", pc_plus4, 32'd0);
    chk("async_valid", {31'd0, inst_valid}, 32'd0);
    cyc(1);
    chk("rst_held_req", {31'd0, imem.imem_req}, 32'd0);
    push_req(32'h0);
    stall = 1'b0;
    #1;
    rst = 1'b0;
    end_test("rst_mid");

    // 3: stall with skid capture, then release
    start_test(1, 32'd0);
    for (int i = 0; i <= 10; i++) push_req(32'(i * 4));
    for (int i = 0; i <= 9; i++) push_load(32'(i * 4));
    wait_inst(32'h20, "stall_wait20");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_hold_inst", INST, 32'h20);
      chk("stall_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_no_req", {31'd0, imem.imem_req}, 32'd0);
    end
    stall = 1'b0;
    end_test("stall");

    // 4: branch while waiting on the fetch of 0x10 (flush overrides stall)
    start_test(3, 32'hC0DE_0000);
    push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
    push_req(32'h10); push_req(32'h100); push_req(32'h104);
    push_load(32'h0); push_load(32'h4); push_load(32'h8); push_load(32'hC);
    push_load(32'h100);
    wait_req(32'h10, "br_wait_req10");
    stall = 1'b1;
    cyc(1);
    branch_taken  = 1'b1;
    branch_target = 32'h103;
    cyc(1);
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("br_flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("br_flush_inst", INST, 32'd0);
    end_test("br_wait");

    // 5: branch in the same cycle as the response
    start_test(1, 32'h5A00_0000);
    push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'h40); push_req(32'h44);
    push_load(32'h0); push_load(32'h4); push_load(32'h40);
    wait_req(32'h8, "brv_wait_req8");
    cyc(1);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    cyc(1);
    branch_taken = 1'b0;
    chk("brv_req", {31'd0, imem.imem_req}, 32'd1);
    chk("brv_addr", imem.imem_addr, 32'h40);
    chk("brv_valid", {31'd0, inst_valid}, 32'd0);
    end_test("br_rvalid");

    // 6: branch and stall together while the skid holds 0xC
    start_test(1, 32'h00A0_0000);
    push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
    push_req(32'h200); push_req(32'h204);
    push_load(32'h0); push_load(32'h4); push_load(32'h8); push_load(32'h200);
    wait_inst(32'h00A0_0008, "hold_wait8");
    stall = 1'b1;
    cyc(2);
    chk("hold_no_req", {31'd0, imem.imem_req}, 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    cyc(1);
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("hold_flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("hold_flush_inst", INST, 32'd0);
    chk("hold_req_addr", imem.imem_addr, 32'h200);
    end_test("br_hold");

    // 7: PC wrap from 0xFFFF_FFFC (reached through a redirect from S_ISSUE)
    start_test(1, 32'h3300_0000);
    push_req(32'h0); push_req(32'hFFFF_FFFC); push_req(32'h0); push_req(32'h4);
    push_load(32'hFFFF_FFFC); push_load(32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    cyc(1);
    branch_taken = 1'b0;
    wait_inst(32'hCCFF_FFFC, "wrap_wait");
    chk("wrap_pc_plus4", pc_plus4, 32'd0);
    chk("wrap_next_addr", imem.imem_addr, 32'd0);
    end_test("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction decoder/control unit. Holds the PC and issues one word read at a time to instruction memory over a req/rvalid handshake. Registers each returned word into an IF/ID register whose INST output drives the decoder's 32-bit instruction input. Handles pipeline stall via a one-entry skid buffer, and branch redirect with flush and discard of in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
ADDR_W, 32, width of the PC and imem_addr.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  from hazard unit: hold the IF/ID register.
branch_taken  input  1  from EX (Branch & zero): redirect fetch this cycle.
branch_target  input  ADDR_W  redirect address; bits [1:0] ignored and forced to 0.
imem_req  output  1  one-cycle read request strobe.
imem_addr  output  ADDR_W  word-aligned read address; valid while imem_req=1.
imem_rdata  input  32  read data; valid only when imem_rvalid=1.
imem_rvalid  input  1  response strobe; at least 1 cycle after req; one outstanding request max.
INST  output  32  IF/ID instruction to the decoder.
pc_out  output  ADDR_W  IF/ID: address of INST.
pc_plus4  output  ADDR_W  IF/ID: pc_out+4, for branch target adder.
inst_valid  output  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=S_ISSUE, skid empty. INST=0, pc_out=0, pc_plus4=0, inst_valid=0. imem_req forced 0 while rst=1.
- INST=0 for a bubble decodes as sll $0 (harmless).
- imem_req=1 only in S_ISSUE with rst=0. imem_addr=pc, combinational.
- PC arithmetic: pc+4, modulo 2^ADDR_W; wrap from 32'hFFFF_FFFC to 0 is silent.
- IF/ID "accept" condition = !inst_valid || !stall.
- S_ISSUE: request issued this cycle.
  - branch_taken: pc<=target, go S_DROP (issued request is stale).
  - Otherwise go S_WAIT.
- S_WAIT (no branch_taken):
  - rvalid and accept: IF/ID<= {rdata, pc, pc+4, valid=1}; pc<=pc+4; go S_ISSUE.
  - rvalid and !accept: skid<= {rdata, pc, pc+4}; pc<=pc+4; go S_HOLD.
  - No rvalid: stay.
- S_WAIT with branch_taken:
  - rvalid same cycle: discard data, pc<=target, go S_ISSUE.
  - No rvalid: pc<=target, go S_DROP.
- S_DROP: on rvalid, discard the data and go S_ISSUE. branch_taken in S_DROP updates pc and stays in S_DROP unless rvalid arrives the same cycle.
- S_HOLD: no request issued.
  - !stall: IF/ID<=skid (valid=1), go S_ISSUE.
  - branch_taken: skid discarded, pc<=target, go S_ISSUE.
- IF/ID register priority, highest first:
  - branch_taken: flush (INST=0, inst_valid=0); pc_out and pc_plus4 don't-care, set to 0.
  - stall && inst_valid: hold.
  - New word loaded (from rdata or skid).
  - Otherwise: bubble (inst_valid=0, INST=0).
- branch_taken overrides stall.
- Steady-state throughput: one instruction per 2 cycles plus memory latency. Latency from req to IF/ID = memory latency + 1 edge.
- No instruction is ever duplicated or dropped, except stale fetches discarded after a redirect.

Test Plan:
- Reset release, 1-cycle memory returning addr-as-data:
  - imem_addr sequence is 0, 4, 8, 12 on successive req pulses.
  - INST shows 0, 4, 8 with pc_plus4 = 4, 8, 12 and inst_valid=1 on each load.
- Assert rst mid-S_WAIT:
  - All outputs go 0 immediately (async); imem_req=0.
  - After release, first req is at RESET_PC.
- stall=1 for 5 cycles while INST=0x20 valid, next response 0x24 arrives:
  - INST holds 0x20; 0x24 is held in skid; no req issued.
  - Stall drop: INST=0x24 next edge, then req addr 0x28.
- branch_taken with target 0x103 while in S_WAIT for addr 0x10:
  - inst_valid=0 next edge; returned data for 0x10 is discarded.
  - Next req addr = 0x100.
- branch_taken and imem_rvalid in the same cycle:
  - Data is discarded, no S_DROP; next cycle req addr = target.
- branch_taken and stall both asserted in S_HOLD:
  - Skid flushed, inst_valid=0, next req addr = target.
- pc=32'hFFFF_FFFC fetched:
  - pc_plus4=0 and next imem_addr=0.
